pipeline_hazard_ctrl: RTL



---
 rtl/pipeline_hazard_ctrl_if.sv | 60 ++++++
 rtl/pipeline_hazard_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl_if
// Purpose  : Stage-state inputs and stall/flush/forward controls exchanged
//            between the five-stage pipeline and its hazard controller.
// Revision : 1.0 - initial release
// ============================================================================
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic [4:0]       ix_dest;
    logic [4:0]       im_dest;
    logic [4:0]       iw_dest;
    logic             ix_write;
    logic             im_write;
    logic             iw_write;
    logic             ix_is_load;
    logic [4:0]       ix_rs;
    logic [4:0]       ix_rt;
    logic             branch_taken;
    logic             dmem_req;
    logic             dmem_ready;

    logic             pc_en;
    logic             if_id_en;
    logic             id_ix_en;
    logic             ix_im_en;
    logic             im_iw_en;
    logic             id_ix_bubble;
    logic             if_id_flush;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cycles;

    // Pipeline side: supplies stage state, consumes controls.
    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt,
        output ix_dest, im_dest, iw_dest, ix_write, im_write, iw_write,
        output ix_is_load, ix_rs, ix_rt, branch_taken, dmem_req, dmem_ready,
        input  pc_en, if_id_en, id_ix_en, ix_im_en, im_iw_en,
        input  id_ix_bubble, if_id_flush, fwd_a_sel, fwd_b_sel,
        input  mem_err, stall_cycles
    );

    // Controller side.
    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt,
        input  ix_dest, im_dest, iw_dest, ix_write, im_write, iw_write,
        input  ix_is_load, ix_rs, ix_rt, branch_taken, dmem_req, dmem_ready,
        output pc_en, if_id_en, id_ix_en, ix_im_en, im_iw_en,
        output id_ix_bubble, if_id_flush, fwd_a_sel, fwd_b_sel,
        output mem_err, stall_cycles
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Purpose  : Stall/flush/forward controller for the IF/ID/IX/IM/IW pipeline
//            with a memory-wait freeze FSM, timeout and stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    pipeline_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    localparam logic [7:0]       c_timeout = 8'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_state_next;
    logic [7:0]       r_wait_cnt;
    logic [7:0]       w_wait_cnt_next;
    logic             r_mem_err;
    logic             w_mem_err_next;
    logic [CNT_W-1:0] r_stall_cycles;

    logic             w_mem_stall;
    logic             w_load_use;
    logic [4:0]       w_run_en;
    logic             w_run_bubble;
    logic             w_run_flush;
    logic [4:0]       w_en;      // {pc, if_id, id_ix, ix_im, im_iw}
    logic             w_bubble;
    logic             w_flush;
    logic [1:0]       w_fwd_a;
    logic [1:0]       w_fwd_b;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       im_wr,
        input logic [4:0] im_dst,
        input logic       iw_wr,
        input logic [4:0] iw_dst
    );
        if (im_wr && (im_dst != 5'd0) && (im_dst == src))
            return 2'd1;
        else if (iw_wr && (iw_dst != 5'd0) && (iw_dst == src))
            return 2'd2;
        else
            return 2'd0;
    endfunction

    assign w_mem_stall = hz.dmem_req & ~hz.dmem_ready;

    assign w_load_use = hz.ix_is_load & hz.ix_write & (hz.ix_dest != 5'd0) &
                        ((hz.id_uses_rs & (hz.id_rs == hz.ix_dest)) |
                         (hz.id_uses_rt & (hz.id_rt == hz.ix_dest)));

    // Flush outranks load-use: the stalled ID instruction is squashed anyway.
    always_comb begin
        w_run_en     = 5'b11111;
        w_run_bubble = 1'b0;
        w_run_flush  = 1'b0;
        if (hz.branch_taken) begin
            w_run_bubble = 1'b1;
            w_run_flush  = 1'b1;
        end else if (w_load_use) begin
            w_run_en     = 5'b00111;
            w_run_bubble = 1'b1;
        end
    end

    always_comb begin
        w_en            = 5'b00000;
        w_bubble        = 1'b0;
        w_flush         = 1'b0;
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        w_mem_err_next  = r_mem_err;

        case (r_state)
            RUN: begin
                if (w_mem_stall) begin
                    w_state_next    = MEM_WAIT;
                    w_wait_cnt_next = 8'd1;
                end else begin
                    w_en     = w_run_en;
                    w_bubble = w_run_bubble;
                    w_flush  = w_run_flush;
                end
            end
            MEM_WAIT: begin
                if (hz.dmem_ready) begin
                    w_en            = w_run_en;
                    w_bubble        = w_run_bubble;
                    w_flush         = w_run_flush;
                    w_state_next    = RUN;
                    w_wait_cnt_next = 8'd0;
                end else begin
                    w_wait_cnt_next = r_wait_cnt + 8'd1;
                    if (w_wait_cnt_next == c_timeout) begin
                        w_state_next   = HALT;
                        w_mem_err_next = 1'b1;
                    end
                end
            end
            HALT: begin
                w_state_next = HALT;
            end
            default: begin
                w_state_next = RUN;
            end
        endcase

        // Reset holds the pipeline frozen and every stage register at NOP.
        if (rst) begin
            w_en     = 5'b00000;
            w_bubble = 1'b1;
            w_flush  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= RUN;
            r_wait_cnt     <= 8'd0;
            r_mem_err      <= 1'b0;
            r_stall_cycles <= '0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
            r_mem_err  <= w_mem_err_next;
            if (!w_en[4] && (r_stall_cycles != c_cnt_max))
                r_stall_cycles <= r_stall_cycles + c_cnt_one;
        end
    end

    always_comb begin
        w_fwd_a = fwd_sel(hz.ix_rs, hz.im_write, hz.im_dest, hz.iw_write, hz.iw_dest);
        w_fwd_b = fwd_sel(hz.ix_rt, hz.im_write, hz.im_dest, hz.iw_write, hz.iw_dest);
        if (rst) begin
            w_fwd_a = 2'd0;
            w_fwd_b = 2'd0;
        end
    end

    assign hz.pc_en        = w_en[4];
    assign hz.if_id_en     = w_en[3];
    assign hz.id_ix_en     = w_en[2];
    assign hz.ix_im_en     = w_en[1];
    assign hz.im_iw_en     = w_en[0];
    assign hz.id_ix_bubble = w_bubble;
    assign hz.if_id_flush  = w_flush;
    assign hz.fwd_a_sel    = w_fwd_a;
    assign hz.fwd_b_sel    = w_fwd_b;
    assign hz.mem_err      = r_mem_err;
    assign hz.stall_cycles = r_stall_cycles;
endmodule
`default_nettype wire
